// File: rtl/pico_pkg.sv
// Shared types and elaboration-time helpers for the PicoRISC-V fetch front-end.
package pico_pkg;

  typedef enum logic {
    S_HOLD  = 1'b0,
    S_FETCH = 1'b1
  } fetch_state_t;

  // ceil(log2(n)); returns 0 for n<=1
  function automatic int lg2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  // counters and pointers never shrink below one bit
  function automatic int max1(input int n);
    return (n < 1) ? 1 : n;
  endfunction

  function automatic int beats_of(input int instr_w, input int bus_w);
    return instr_w / bus_w;
  endfunction

endpackage

// File: rtl/pico_sync_fifo.sv
// Synchronous FIFO with flush; head entry is read straight from the storage registers.
module pico_sync_fifo
  import pico_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4,
  parameter int PTR_W = max1(lg2(DEPTH)),
  parameter int CNT_W = lg2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  assign head_data  = mem[rd_ptr];
  assign head_valid = (count != '0);

endmodule

// File: rtl/pico_fetch_unit.sv
// Instruction fetch front-end: assembles BUS_W beats into instructions and queues them with their PC.
// Optional PICO_FETCH_PERF_EN adds saturating fetched/flushed event counters.
module pico_fetch_unit
  import pico_pkg::*;
#(
  parameter int PC_W     = 8,
  parameter int INSTR_W  = 16,
  parameter int BUS_W    = 8,
  parameter int DEPTH    = 4,
  parameter int RESET_PC = 0
) (
  input  logic                                  clk,
  input  logic                                  rst,
  output logic                                  mem_req,
  output logic [PC_W+lg2(INSTR_W/BUS_W)-1:0]    mem_addr,
  input  logic                                  mem_ack,
  input  logic [BUS_W-1:0]                      mem_rdata,
  output logic                                  instr_valid,
  input  logic                                  instr_ready,
  output logic [INSTR_W-1:0]                    instr_data,
  output logic [PC_W-1:0]                       instr_pc,
  input  logic                                  redirect_valid,
  input  logic [PC_W-1:0]                       redirect_pc
`ifdef PICO_FETCH_PERF_EN
  ,
  output logic [15:0]                           perf_fetched,
  output logic [15:0]                           perf_flushed
`endif
);

  localparam int BEATS    = beats_of(INSTR_W, BUS_W);
  localparam int BEATS_LG = lg2(BEATS);
  localparam int BEAT_W   = max1(BEATS_LG);
  localparam int ADDR_W   = PC_W + BEATS_LG;
  localparam int CNT_W    = lg2(DEPTH) + 1;

  fetch_state_t        state;
  logic [PC_W-1:0]     pc;
  logic [BEAT_W-1:0]   beat;
  logic [INSTR_W-1:0]  asm_q, asm_nxt;
  logic                fetch_ack, last_beat, push, pop, space;
  logic [CNT_W-1:0]    fifo_count, count_nxt;

  function automatic logic [ADDR_W-1:0] addr_of(input logic [PC_W-1:0] p,
                                                input logic [BEAT_W-1:0] b);
    return (ADDR_W'(p) << BEATS_LG) | ADDR_W'(b);
  endfunction

  assign fetch_ack = (state == S_FETCH) && mem_ack;
  assign last_beat = (beat == BEAT_W'(BEATS - 1));
  assign push      = fetch_ack && last_beat && !redirect_valid;
  assign pop       = instr_valid && instr_ready && !redirect_valid;

  // A new instruction is only started if its eventual push is guaranteed a slot.
  assign count_nxt = fifo_count + CNT_W'(push) - CNT_W'(pop);
  assign space     = (count_nxt < CNT_W'(DEPTH));

  always_comb begin
    asm_nxt = asm_q;
    asm_nxt[int'(beat)*BUS_W +: BUS_W] = mem_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_HOLD;
      pc       <= PC_W'(RESET_PC);
      beat     <= '0;
      asm_q    <= '0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
    end else if (redirect_valid) begin
      state    <= S_FETCH;
      pc       <= redirect_pc;
      beat     <= '0;
      mem_req  <= 1'b1;
      mem_addr <= addr_of(redirect_pc, '0);
    end else if (state == S_FETCH) begin
      if (mem_ack) begin
        asm_q <= asm_nxt;
        if (last_beat) begin
          beat <= '0;
          pc   <= pc + 1'b1;
          if (space) begin
            mem_addr <= addr_of(pc + 1'b1, '0);
          end else begin
            state   <= S_HOLD;
            mem_req <= 1'b0;
          end
        end else begin
          beat     <= beat + 1'b1;
          mem_addr <= addr_of(pc, beat + 1'b1);
        end
      end
    end else if (space) begin
      state    <= S_FETCH;
      mem_req  <= 1'b1;
      mem_addr <= addr_of(pc, '0);
    end
  end

  pico_sync_fifo #(
    .WIDTH (INSTR_W + PC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_data  ({pc, asm_nxt}),
    .pop        (pop),
    .flush      (redirect_valid),
    .head_data  ({instr_pc, instr_data}),
    .head_valid (instr_valid),
    .count      (fifo_count)
  );

`ifdef PICO_FETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      if (push && perf_fetched != 16'hFFFF) perf_fetched <= perf_fetched + 16'd1;
      if (redirect_valid && perf_flushed != 16'hFFFF) perf_flushed <= perf_flushed + 16'd1;
    end
  end
`else
  // event counters are not built in this configuration
`endif

endmodule

// File: tb/tb_pico_fetch_unit.sv
// Randomized scoreboard bench for pico_fetch_unit against an address-arithmetic reference stream.
module tb_pico_fetch_unit;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 16;
  localparam int BUS_W   = 8;
  localparam int DEPTH   = 4;
  localparam int BEATS   = 2;
  localparam int AW      = 9;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               mem_req, mem_ack;
  logic [AW-1:0]      mem_addr;
  logic [BUS_W-1:0]   mem_rdata;
  logic               instr_valid;
  logic               instr_ready = 1'b1;
  logic [INSTR_W-1:0] instr_data;
  logic [PC_W-1:0]    instr_pc;
  logic               redirect_valid = 1'b0;
  logic [PC_W-1:0]    redirect_pc = '0;
  logic               ack_en = 1'b1;
`ifdef PICO_FETCH_PERF_EN
  logic [15:0]        perf_fetched, perf_flushed;
`endif

  assign mem_ack   = mem_req & ack_en;
  assign mem_rdata = mem_addr[7:0];

  always #5 clk = ~clk;

  pico_fetch_unit #(
    .PC_W(PC_W), .INSTR_W(INSTR_W), .BUS_W(BUS_W), .DEPTH(DEPTH), .RESET_PC(0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef PICO_FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_flushed   (perf_flushed)
`endif
  );

  typedef struct {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   gen_pc   = 0;
  int   total    = 0;
  int   bad      = 0;
  int   pop_cnt  = 0;
  int   ack_mode = 0;
  int   wait_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // instruction at index p is the little-endian concatenation of its beats' byte addresses
  function automatic logic [INSTR_W-1:0] exp_instr(input int p);
    logic [INSTR_W-1:0] d;
    d = '0;
    for (int b = 0; b < BEATS; b++) begin
      int a;
      a = (p * BEATS + b) % (1 << AW);
      d[b*BUS_W +: BUS_W] = 8'(a);
    end
    return d;
  endfunction

  task automatic restart(input int p);
    exp_q.delete();
    gen_pc = p;
  endtask

  task automatic topup();
    while (exp_q.size() < 16) begin
      exp_q.push_back('{pc: PC_W'(gen_pc), data: exp_instr(gen_pc)});
      gen_pc = (gen_pc + 1) % (1 << PC_W);
    end
  endtask

  task automatic set_ack();
    case (ack_mode)
      0: ack_en = 1'b1;
      1: ack_en = ($urandom_range(0, 3) != 0);
      default: begin
        if (mem_req) begin
          ack_en   = (wait_cnt == 3);
          wait_cnt = ack_en ? 0 : wait_cnt + 1;
        end else begin
          ack_en   = 1'b0;
          wait_cnt = 0;
        end
      end
    endcase
  endtask

  task automatic cycle(input logic rdy, input logic rv, input logic [PC_W-1:0] rpc);
    @(posedge clk);
    #1;
    instr_ready    = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    if (rv) restart(int'(rpc));
    topup();
    set_ack();
  endtask

  // raise a redirect in the cycle we are already standing in
  task automatic redirect_now(input logic [PC_W-1:0] rpc);
    redirect_valid = 1'b1;
    redirect_pc    = rpc;
    restart(int'(rpc));
    topup();
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_instr_valid", 32'(instr_valid), 0);
    check("rst_instr_data", 32'(instr_data), 0);
    check("rst_instr_pc", 32'(instr_pc), 0);
    redirect_valid = 1'b0;
    restart(0);
    topup();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // monitor: pops the scoreboard on every accepted instruction and checks bus protocol
  logic          p_rd = 1'b0, p_wait = 1'b0;
  logic [PC_W-1:0] p_rpc = '0;
  logic [AW-1:0] p_addr = '0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        p_rd   = 1'b0;
        p_wait = 1'b0;
      end else begin
        if (p_rd) begin
          check("redir_valid", 32'(instr_valid), 0);
          check("redir_req", 32'(mem_req), 1);
          check("redir_addr", 32'(mem_addr), 32'(p_rpc) * BEATS);
        end else if (p_wait) begin
          check("stall_req", 32'(mem_req), 1);
          check("stall_addr", 32'(mem_addr), 32'(p_addr));
        end
        if (instr_valid && instr_ready && !redirect_valid) begin
          pop_cnt++;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_empty: got pc %0h with no expected entry", instr_pc);
          end else begin
            e = exp_q.pop_front();
            check("instr_pc", 32'(instr_pc), 32'(e.pc));
            check("instr_data", 32'(instr_data), 32'(e.data));
          end
        end
        p_rd   = redirect_valid;
        p_rpc  = redirect_pc;
        p_wait = mem_req && !mem_ack && !redirect_valid;
        p_addr = mem_addr;
      end
    end
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int p0;
    logic found;
    restart(0);
    topup();
    #2;
    check("init_mem_req", 32'(mem_req), 0);
    check("init_mem_addr", 32'(mem_addr), 0);
    check("init_instr_valid", 32'(instr_valid), 0);
    check("init_instr_data", 32'(instr_data), 0);
    check("init_instr_pc", 32'(instr_pc), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // sustained stream: one instruction per BEATS cycles
    repeat (10) cycle(1'b1, 1'b0, '0);
    p0 = pop_cnt;
    repeat (20) cycle(1'b1, 1'b0, '0);
    check("throughput", 32'(pop_cnt - p0), 10);

    // async reset mid-fetch, then fill the FIFO with the consumer stalled
    instr_ready = 1'b0;
    pulse_reset();
    repeat (20) cycle(1'b0, 1'b0, '0);
    check("full_mem_req", 32'(mem_req), 0);
    check("full_mem_addr", 32'(mem_addr), 7);
    check("full_instr_valid", 32'(instr_valid), 1);
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      cycle(1'b1, 1'b0, '0);
      found = mem_req;
    end
    check("resume_seen", 32'(found), 1);
    check("resume_addr", 32'(mem_addr), 8);

    // redirect while pc5's second beat is on the bus
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle(1'b1, 1'b0, '0);
      found = mem_req && (mem_addr == 9'h00B);
    end
    check("pc5_beat1_seen", 32'(found), 1);
    redirect_now(8'h40);
    repeat (20) cycle(1'b1, 1'b0, '0);

    // pc wrap at the top of the address space
    cycle(1'b1, 1'b1, 8'hFF);
    repeat (20) cycle(1'b1, 1'b0, '0);

    // slow memory: each beat acked after three wait cycles
    ack_mode = 2;
    repeat (60) cycle(1'b1, 1'b0, '0);

    // random ack, backpressure and redirects
    ack_mode = 1;
    repeat (600) cycle($urandom_range(0, 9) < 7, $urandom_range(0, 99) < 3, PC_W'($urandom));

`ifdef PICO_FETCH_PERF_EN
    ack_mode = 0;
    instr_ready = 1'b0;
    pulse_reset();
    repeat (20) cycle(1'b0, 1'b0, '0);
    cycle(1'b0, 1'b1, 8'h10);
    repeat (20) cycle(1'b0, 1'b0, '0);
    cycle(1'b0, 1'b1, 8'h20);
    repeat (20) cycle(1'b0, 1'b0, '0);
    check("perf_fetched", 32'(perf_fetched), 12);
    check("perf_flushed", 32'(perf_flushed), 2);
`endif

    ack_mode = 0;
    repeat (10) cycle(1'b1, 1'b0, '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
